// File: rtl/cal_abs.sv
// rtl/cal_abs.sv - streaming complex magnitude, floor(sqrt(re^2 + im^2)), fixed latency
// Two square/sum stages followed by one restoring square-root stage per result bit.
module cal_abs #(
  parameter int DW  = 8,
  parameter int LAT = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          val_i,
  input  logic [DW-1:0] real_i,
  input  logic [DW-1:0] imag_i,
  output logic [DW-1:0] abs_o,
  output logic          val_o
);

  localparam int SQW  = 2*DW - 1;
  localparam int SUMW = 2*DW;
  localparam int REMW = DW + 2;

  logic [SQW-1:0]  w_re_x;
  logic [SQW-1:0]  w_im_x;
  logic [SQW-1:0]  r_sq_re;
  logic [SQW-1:0]  r_sq_im;
  logic [SUMW-1:0] r_sum;
  logic [LAT-1:0]  r_val;

  logic [REMW-1:0] r_rem  [DW-1];
  logic [SUMW-1:0] r_rad  [DW-1];
  logic [DW-1:0]   r_root [DW];

  logic [REMW-1:0] w_rem_in  [DW];
  logic [DW-1:0]   w_root_in [DW];
  logic [1:0]      w_pair    [DW];
  logic [REMW+1:0] w_cur     [DW];
  logic [REMW+1:0] w_trial   [DW];
  logic            w_ge      [DW];
  logic [REMW-1:0] w_rem_nx  [DW];
  logic [DW-1:0]   w_root_nx [DW];

  // Sign-extend before squaring so -128 yields +16384 instead of wrapping.
  assign w_re_x = {{(SQW-DW){real_i[DW-1]}}, real_i};
  assign w_im_x = {{(SQW-DW){imag_i[DW-1]}}, imag_i};

  always_comb begin
    w_rem_in[0]  = '0;
    w_root_in[0] = '0;
    w_pair[0]    = r_sum[SUMW-1 -: 2];
    for (int s = 1; s < DW; s++) begin
      w_rem_in[s]  = r_rem[s-1];
      w_root_in[s] = r_root[s-1];
      w_pair[s]    = r_rad[s-1][SUMW-1-2*s -: 2];
    end
    for (int s = 0; s < DW; s++) begin
      w_cur[s]     = {w_rem_in[s], w_pair[s]};
      w_trial[s]   = {2'b00, w_root_in[s], 2'b01};
      w_ge[s]      = (w_cur[s] >= w_trial[s]);
      w_rem_nx[s]  = w_ge[s] ? REMW'(w_cur[s] - w_trial[s]) : REMW'(w_cur[s]);
      w_root_nx[s] = {w_root_in[s][DW-2:0], w_ge[s]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sq_re <= '0;
      r_sq_im <= '0;
      r_sum   <= '0;
      r_val   <= '0;
      for (int s = 0; s < DW; s++) r_root[s] <= '0;
      for (int s = 0; s < DW-1; s++) begin
        r_rem[s] <= '0;
        r_rad[s] <= '0;
      end
    end else begin
      r_sq_re <= w_re_x * w_re_x;
      r_sq_im <= w_im_x * w_im_x;
      r_sum   <= {1'b0, r_sq_re} + {1'b0, r_sq_im};
      r_val   <= {r_val[LAT-2:0], val_i};
      for (int s = 0; s < DW; s++) r_root[s] <= w_root_nx[s];
      for (int s = 0; s < DW-1; s++) r_rem[s] <= w_rem_nx[s];
      // Radicand travels alongside its partial root; each stage reads its own bit pair.
      r_rad[0] <= r_sum;
      for (int s = 1; s < DW-1; s++) r_rad[s] <= r_rad[s-1];
    end
  end

  assign abs_o = r_root[DW-1];
  assign val_o = r_val[LAT-1];

endmodule

// File: tb/tb_cal_abs.sv
// tb/tb_cal_abs.sv - scoreboard bench for cal_abs with directed, random and exhaustive stimulus
module tb_cal_abs;

  logic       clk = 1'b0;
  logic       rst;
  logic       val_i;
  logic [7:0] real_i;
  logic [7:0] imag_i;
  logic [7:0] abs_o;
  logic       val_o;

  cal_abs #(.DW(8), .LAT(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .val_i  (val_i),
    .real_i (real_i),
    .imag_i (imag_i),
    .abs_o  (abs_o),
    .val_o  (val_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          exp_abs;
    int unsigned issue;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_abs(input int re, input int im);
    int n;
    int r;
    n = re*re + im*im;
    r = 0;
    while ((r+1)*(r+1) <= n) r++;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] re, input logic [7:0] im, input int exp);
    exp_t e;
    @(negedge clk);
    val_i  = v;
    real_i = re;
    imag_i = im;
    if (v) begin
      e.exp_abs = exp;
      e.issue   = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send_ref(input bit v, input logic [7:0] re, input logic [7:0] im);
    drive(v, re, im, ref_abs(int'($signed(re)), int'($signed(im))));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: every val_o pulse must match the oldest outstanding sample, 10 clocks after issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && val_o === 1'b1) begin
        n_pulse++;
        if (sb.size() == 0) begin
          check("extra_val_o", 1, 0);
        end else begin
          e = sb.pop_front();
          check("abs", abs_o, e.exp_abs);
          check("latency", cyc - e.issue, 10);
        end
      end
    end
  end

  initial begin
    int p0;
    rst    = 1'b1;
    val_i  = 1'b0;
    real_i = 8'h00;
    imag_i = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_abs", abs_o, 0);
    check("reset_val", val_o, 0);
    rst = 1'b0;

    drive(1'b1, 8'h03, 8'h04, 5);
    drive(1'b1, 8'hFD, 8'h04, 5);
    drive(1'b1, 8'h00, 8'h00, 0);
    drive(1'b1, 8'h01, 8'h01, 1);

    drive(1'b1, 8'h80, 8'h80, 181);
    drive(1'b1, 8'h80, 8'h00, 128);
    drive(1'b1, 8'h7F, 8'h00, 127);
    drive(1'b1, 8'h7F, 8'h7F, 179);
    drive(1'b1, 8'h80, 8'h7F, 180);
    drive(1'b1, 8'h00, 8'h80, 128);
    drive(1'b1, 8'h01, 8'h00, 1);
    idle(2);

    drive(1'b1, 8'h06, 8'h08, 10);
    drive(1'b0, 8'h06, 8'h08, 0);
    drive(1'b1, 8'h05, 8'h0C, 13);
    drive(1'b1, 8'h05, 8'h0C, 13);
    drive(1'b0, 8'h05, 8'h0C, 0);
    drain();

    for (int i = 0; i < 400; i++)
      send_ref($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom));
    idle(1);
    drain();

    for (int i = 0; i < 5; i++) send_ref(1'b1, 8'($urandom), 8'($urandom));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_abs", abs_o, 0);
    check("async_rst_val", val_o, 0);
    val_i = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(15);
    drive(1'b1, 8'hFD, 8'hFC, 5);
    idle(1);
    drain();

    p0 = n_pulse;
    for (int re = 0; re < 256; re++)
      for (int im = 0; im < 256; im++)
        send_ref(1'b1, 8'(re), 8'(im));
    idle(1);
    drain();
    check("exhaustive_pulses", n_pulse - p0, 65536);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cal_abs.md
Name: cal_abs

Overview:
- Streaming complex-magnitude unit: abs_o = floor(sqrt(real_i^2 + imag_i^2)).
- Accepts one complex sample per clock; fully pipelined with fixed latency.
- Sits after the FFT/complex datapath and feeds magnitude samples downstream, with a valid flag aligned to each result.

Parameters:
- DW, 8, input component width (two's complement) and output width.
- LAT, 10, pipeline latency in clocks; fixed for DW=8, not user-tunable.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- val_i  input  1  input valid; real_i/imag_i are sampled on a rising edge where val_i=1.
- real_i  input  8  real part, signed two's complement (-128..127).
- imag_i  input  8  imaginary part, signed two's complement (-128..127).
- abs_o  output  8  magnitude, unsigned (0..181).
- val_o  output  1  high for exactly one clock per accepted sample, aligned with abs_o.

Behaviour:
- Reset (asynchronous, active-high): all pipeline registers clear immediately. abs_o=0 and val_o=0 while rst=1 and until the first valid sample emerges after release. In-flight samples are discarded.
- Throughput: one sample per clock, no back-pressure. val_i may stay high indefinitely or toggle arbitrarily.
- Latency: a sample sampled at edge k produces abs_o/val_o registered at edge k+10.
  - val_o is val_i delayed by exactly 10 registers.
  - Gaps in val_i appear as identical gaps in val_o.
- Stage 1: register the signed squares re^2 and im^2.
  - Each square is 15 bits unsigned; max value 16384, from -128.
- Stage 2: register sum = re^2 + im^2.
  - 16 bits unsigned; max 32768, when both inputs are -128.
- Stages 3-10: pipelined digit-by-digit (non-restoring or restoring) integer square root of the 16-bit sum.
  - One result bit per stage, MSB first; 8 stages give an 8-bit root.
  - Each stage carries its remainder, partial root and radicand forward.
- Result is the truncated (floor) root; no rounding.
  - Example: sum=2 gives abs_o=1.
- Output register: abs_o and val_o are driven directly from flops (no combinational path from inputs).
- Invalid cycles: the data pipeline is free-running; abs_o is don't-care when val_o=0.
- Valid tracking: a single-bit shift chain carries val_i through the pipeline and is reset to 0.
- Overflow: none possible. Max result is 181 (0xB5), which fits 8 bits unsigned.
- Sign handling: -128 must be squared correctly as 16384, with no abs() overflow. Square the sign-extended value; do not negate in 8 bits.
- Bit-exact requirement: output must match floor(sqrt(re*re + im*im)) for all 65536 input pairs.

Test Plan:
- Basic: rst high then low; stream (0x03,0x04), (0xFD,0x04), (0x00,0x00), (0x01,0x01) with val_i=1. Required: val_o rises 10 clocks after the first sample; abs_o = 0x05, 0x05, 0x00, 0x01 on consecutive cycles.
- Extremes: (0x80,0x80) -> 0xB5; (0x80,0x00) -> 0x80; (0x7F,0x00) -> 0x7F; (0x7F,0x7F) -> 0xB3 (179); (0x80,0x7F) -> 0xB4 (180).
- Valid gaps: val_i pattern 1,0,1,1,0 with samples (0x06,0x08) and (0x05,0x0C) -> val_o reproduces 1,0,1,1,0 starting 10 clocks later. Valid outputs are 0x0A, 0x0D, 0x0D; no extra or missing val_o pulses.
- Reset mid-stream: assert rst asynchronously (between edges) while 5 samples are in flight. Required: val_o=0 and abs_o=0 immediately. After release, no stale results appear; the next sample returns after 10 clocks.
- Exhaustive: stream all 65536 (real_i, imag_i) pairs back-to-back. Compare every abs_o against a floor(sqrt(re^2+im^2)) golden file at val_o; zero mismatches and exactly 65536 val_o pulses.
